// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage pipeline hazard control.
// Forward selects, divider FSM states, reg-zero id.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_div_fsm.sv
// Multicycle divider sequencer: start/done handshake,
// watchdog timeout and exception abort.
module hazard_div_fsm
  import pipe_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic div_e,
  input  logic div_done,
  input  logic excp_m,
  output logic div_stall,
  output logic div_start,
  output logic div_cancel,
  output logic div_err
);

  localparam int CW = $clog2(DIV_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          cancel_q, cancel_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      cancel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      cancel_q <= cancel_d;
      err_q    <= err_d;
    end
  end

  // An aborted div is still in EX while cancel pulses; skip
  // one restart so it can leave the stage.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    cancel_d = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (div_e && !excp_m && !cancel_q) begin
          state_d = DIV_RUN;
          cnt_d   = '0;
          start_d = 1'b1;
        end
      end
      DIV_RUN: begin
        if (excp_m) begin
          state_d  = DIV_IDLE;
          cnt_d    = '0;
          cancel_d = 1'b1;
        end else if (div_done) begin
          state_d = DIV_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DIV_IDLE;
          cnt_d    = '0;
          cancel_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  assign div_stall = (state_q == DIV_RUN)
                   || (state_q == DIV_IDLE && div_e && !cancel_q);
  assign div_start  = start_q;
  assign div_cancel = cancel_q;
  assign div_err    = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use/branch
// stalls, divider sequencing and exception flushes.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] wreg_e,
  input  logic [REG_AW-1:0] wreg_m,
  input  logic [REG_AW-1:0] wreg_w,
  input  logic              regwrite_e,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              memtoreg_e,
  input  logic              memtoreg_m,
  input  logic              branch_d,
  input  logic              div_e,
  input  logic              div_done,
  input  logic              excp_m,
  output logic              en_f,
  output logic              en_d,
  output logic              en_e,
  output logic              en_m,
  output logic              clr_d,
  output logic              clr_e,
  output logic              clr_m,
  output logic              clr_w,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              div_start,
  output logic              div_cancel,
  output logic              div_err
);

  function automatic logic hit(
    input logic [REG_AW-1:0] dst,
    input logic [REG_AW-1:0] src
  );
    return (dst != REG_AW'(REG_ZERO)) && (dst == src);
  endfunction

  function automatic fwd_sel_e fwd_sel(
    input logic [REG_AW-1:0] src
  );
    if (regwrite_m && hit(wreg_m, src)) return FWD_MEM;
    if (regwrite_w && hit(wreg_w, src)) return FWD_WB;
    return FWD_REG;
  endfunction

  logic div_stall;
  logic lw_stall;
  logic br_stall;
  logic e_hit_d;
  logic m_hit_d;

  hazard_div_fsm #(
    .DIV_TIMEOUT(DIV_TIMEOUT)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_e     (div_e),
    .div_done  (div_done),
    .excp_m    (excp_m),
    .div_stall (div_stall),
    .div_start (div_start),
    .div_cancel(div_cancel),
    .div_err   (div_err)
  );

  assign fwd_a_e = fwd_sel(rs_e);
  assign fwd_b_e = fwd_sel(rt_e);
  assign fwd_a_d = regwrite_m && hit(wreg_m, rs_d);
  assign fwd_b_d = regwrite_m && hit(wreg_m, rt_d);

  assign e_hit_d  = hit(wreg_e, rs_d) || hit(wreg_e, rt_d);
  assign m_hit_d  = hit(wreg_m, rs_d) || hit(wreg_m, rt_d);
  assign lw_stall = memtoreg_e && e_hit_d;
  assign br_stall = branch_d
                 && ((regwrite_e && e_hit_d)
                  || (memtoreg_m && m_hit_d));

  always_comb begin
    en_f  = 1'b1;
    en_d  = 1'b1;
    en_e  = 1'b1;
    en_m  = 1'b1;
    clr_d = 1'b0;
    clr_e = 1'b0;
    clr_m = 1'b0;
    clr_w = 1'b0;
    unique case (1'b1)
      excp_m: begin
        clr_d = 1'b1;
        clr_e = 1'b1;
        clr_m = 1'b1;
        clr_w = 1'b1;
      end
      (!excp_m && div_stall): begin
        en_f  = 1'b0;
        en_d  = 1'b0;
        en_e  = 1'b0;
        en_m  = 1'b0;
        clr_w = 1'b1;
      end
      (!excp_m && !div_stall && (lw_stall || br_stall)): begin
        en_f  = 1'b0;
        en_d  = 1'b0;
        clr_e = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the
// combinational paths, sequences for the divider FSM.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs_d = '0, rt_d = '0, rs_e = '0, rt_e = '0;
  logic [4:0] wreg_e = '0, wreg_m = '0, wreg_w = '0;
  logic       regwrite_e = 0, regwrite_m = 0, regwrite_w = 0;
  logic       memtoreg_e = 0, memtoreg_m = 0, branch_d = 0;
  logic       div_e = 0, div_done = 0, excp_m = 0;
  logic       en_f, en_d, en_e, en_m;
  logic       clr_d, clr_e, clr_m, clr_w;
  logic       fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       div_start, div_cancel, div_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .branch_d(branch_d), .div_e(div_e),
    .div_done(div_done), .excp_m(excp_m),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
    .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m),
    .clr_w(clr_w),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .div_start(div_start), .div_cancel(div_cancel),
    .div_err(div_err)
  );

  typedef struct packed {
    logic [4:0]  rs_d, rt_d, rs_e, rt_e;
    logic [4:0]  wreg_e, wreg_m, wreg_w;
    logic        rw_e, rw_m, rw_w, mr_e, mr_m, br_d, excp;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    rs_d = v.rs_d; rt_d = v.rt_d;
    rs_e = v.rs_e; rt_e = v.rt_e;
    wreg_e = v.wreg_e; wreg_m = v.wreg_m; wreg_w = v.wreg_w;
    regwrite_e = v.rw_e; regwrite_m = v.rw_m;
    regwrite_w = v.rw_w;
    memtoreg_e = v.mr_e; memtoreg_m = v.mr_m;
    branch_d = v.br_d; excp_m = v.excp;
  endtask

  function automatic logic [13:0] outs();
    return {en_f, en_d, en_e, en_m,
            clr_d, clr_e, clr_m, clr_w,
            fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e};
  endfunction

  initial begin
    vec_t v;
    // exp = {en fdem, clr demw, fwd_d ab, fwd_a_e, fwd_b_e}
    v = '0; v.exp = 14'b1111_0000_00_00_00; vecs.push_back(v);
    v = '0; v.rs_e = 3; v.rw_m = 1; v.wreg_m = 3;
    v.rw_w = 1; v.wreg_w = 3;
    v.exp = 14'b1111_0000_00_10_00; vecs.push_back(v);
    v = '0; v.rw_m = 1; v.rw_w = 1;
    v.exp = 14'b1111_0000_00_00_00; vecs.push_back(v);
    v = '0; v.rs_e = 3; v.rw_m = 1; v.wreg_m = 4;
    v.rw_w = 1; v.wreg_w = 3;
    v.exp = 14'b1111_0000_00_01_00; vecs.push_back(v);
    v = '0; v.rt_e = 7; v.wreg_m = 7; v.rw_w = 1; v.wreg_w = 7;
    v.exp = 14'b1111_0000_00_00_01; vecs.push_back(v);
    v = '0; v.mr_e = 1; v.rw_e = 1; v.wreg_e = 5; v.rt_d = 5;
    v.exp = 14'b0011_0100_00_00_00; vecs.push_back(v);
    v = '0; v.mr_e = 1; v.rw_e = 1;
    v.exp = 14'b1111_0000_00_00_00; vecs.push_back(v);
    v = '0; v.br_d = 1; v.rs_d = 6; v.rw_e = 1; v.wreg_e = 6;
    v.exp = 14'b0011_0100_00_00_00; vecs.push_back(v);
    v = '0; v.br_d = 1; v.rt_d = 8; v.mr_m = 1; v.rw_m = 1;
    v.wreg_m = 8;
    v.exp = 14'b0011_0100_01_00_00; vecs.push_back(v);
    v = '0; v.br_d = 1; v.rs_d = 9; v.rw_m = 1; v.wreg_m = 9;
    v.exp = 14'b1111_0000_10_00_00; vecs.push_back(v);
    v = '0; v.rs_d = 6; v.rw_e = 1; v.wreg_e = 6;
    v.exp = 14'b1111_0000_00_00_00; vecs.push_back(v);
    v = '0; v.mr_e = 1; v.wreg_e = 5; v.rt_d = 5; v.excp = 1;
    v.exp = 14'b1111_1111_00_00_00; vecs.push_back(v);
    v = '0; v.rs_d = 2; v.rt_d = 2; v.rs_e = 2; v.rt_e = 2;
    v.rw_m = 1; v.wreg_m = 2; v.rw_w = 1; v.wreg_w = 2;
    v.exp = 14'b1111_0000_11_10_10; vecs.push_back(v);
    v = '0; v.mr_e = 1; v.wreg_e = 4; v.rs_d = 4;
    v.exp = 14'b0011_0100_00_00_00; vecs.push_back(v);

    #12;
    chk("rst_outs", 32'(outs()), 32'(14'b1111_0000_00_00_00));
    chk("rst_div", 32'({div_start, div_cancel, div_err}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    v = '0;
    apply(v);
    step();

    // divider completes after 33 RUN cycles
    div_e = 1'b1;
    for (int c = 0; c <= 33; c++) begin
      div_done = (c == 33);
      #1;
      chk($sformatf("div_en_e c%0d", c), 32'(en_e), 32'(0));
      chk($sformatf("div_start c%0d", c),
          32'(div_start), 32'(c == 1));
      if (c == 0)
        chk("div_shape", 32'({en_f, en_d, en_m, clr_w}),
            32'(4'b0001));
      step();
    end
    div_done = 1'b0;
    #1;
    chk("done_rel", 32'({en_f, en_d, en_e, en_m, clr_w}),
        32'(5'b11110));
    div_e = 1'b0;
    step();
    chk("done_idle", 32'(outs()), 32'(14'b1111_0000_00_00_00));

    // exception at RUN cycle 10, div_done ignored in IDLE
    div_e = 1'b1;
    for (int c = 0; c < 10; c++) begin
      div_done = (c == 0);
      #1;
      chk($sformatf("ex_en_e c%0d", c), 32'(en_e), 32'(0));
      step();
    end
    excp_m = 1'b1;
    div_done = 1'b1;
    #1;
    chk("excp_outs", 32'({en_f, en_d, en_e, en_m,
        clr_d, clr_e, clr_m, clr_w}), 32'(8'hff));
    step();
    excp_m = 1'b0;
    div_done = 1'b0;
    div_e = 1'b0;
    #1;
    chk("excp_cancel", 32'(div_cancel), 32'(1));
    chk("excp_idle", 32'({en_e, div_err}), 32'(2'b10));
    step();
    chk("excp_cancel_end", 32'(div_cancel), 32'(0));

    // watchdog: no div_done for 40 RUN cycles
    div_e = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      #1;
      chk($sformatf("to_en_e c%0d", c), 32'(en_e), 32'(0));
      chk($sformatf("to_flags c%0d", c),
          32'({div_cancel, div_err}), 32'(0));
      step();
    end
    #1;
    chk("to_abort", 32'({div_cancel, div_err, en_e}),
        32'(3'b111));
    div_e = 1'b0;
    step();
    chk("to_cancel_end", 32'({div_cancel, div_err}),
        32'(2'b01));
    step(); step(); step();
    chk("to_sticky", 32'(div_err), 32'(1));

    // asynchronous reset in the middle of RUN
    div_e = 1'b1;
    for (int c = 0; c < 5; c++) step();
    div_e = 1'b0;
    #1;
    chk("ar_run", 32'({en_e, div_err}), 32'(2'b01));
    rst_n = 1'b0;
    #1;
    chk("ar_en", 32'(outs()), 32'(14'b1111_0000_00_00_00));
    chk("ar_div", 32'({div_start, div_cancel, div_err}),
        32'(0));
    rst_n = 1'b1;
    step();
    chk("ar_after", 32'({en_e, div_start, div_err}),
        32'(3'b100));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
